// File: rtl/mpi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : mpi_ram_slave
// Brief    : MPI/Q-bus RAM slave answering sync/din/dout cycles with rply.
// Revision : 1.0  initial release
// ============================================================================
module mpi_ram_slave #(
  parameter logic [15:0] BASE = 16'h0000,
  parameter int unsigned AW   = 13,
  parameter int unsigned WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire  [15:0] ad,
  input  logic        sync,
  input  logic        din,
  input  logic        dout,
  input  logic        wtbt,
  output logic        rply,
  output logic        sel_o
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_addr  = 3'd1;
  localparam logic [2:0] c_st_rwait = 3'd2;
  localparam logic [2:0] c_st_rdrv  = 3'd3;
  localparam logic [2:0] c_st_wwait = 3'd4;
  localparam logic [2:0] c_st_wack  = 3'd5;
  localparam logic [2:0] c_st_hold  = 3'd6;

  localparam logic [3:0] c_wait  = WAIT[3:0];
  localparam int         c_depth = 1 << AW;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [3:0]    r_cnt;
  logic          w_load;
  logic          w_wr_en;
  logic          w_ad_oe;
  logic          r_miss;
  logic [AW-1:0] r_idx;
  logic          r_lane;
  logic [15:0]   r_rdata;
  logic [16:0]   w_diff;
  logic          w_hit;
  logic          w_latch;

  logic [15:0]   r_mem [c_depth];

  // Addresses below BASE wrap to a huge 17-bit offset and therefore miss.
  assign w_diff  = {1'b0, ad} - {1'b0, BASE};
  assign w_hit   = (w_diff[16:AW+1] == '0);
  assign w_latch = (r_state == c_st_idle) && sync && !r_miss;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_latch && w_hit) w_state_nxt = c_st_addr;
      end
      c_st_addr: begin
        if (!sync) begin
          w_state_nxt = c_st_idle;
        end else if (!din) begin
          w_state_nxt = c_st_rwait;
          w_load      = 1'b1;
        end else if (!dout) begin
          w_state_nxt = c_st_wwait;
          w_load      = 1'b1;
        end
      end
      c_st_rwait: begin
        if (!sync) w_state_nxt = c_st_idle;
        else if (r_cnt == 4'd0) w_state_nxt = c_st_rdrv;
      end
      c_st_rdrv: begin
        if (!sync) w_state_nxt = c_st_idle;
        else if (din) w_state_nxt = c_st_hold;
      end
      c_st_wwait: begin
        if (!sync) begin
          w_state_nxt = c_st_idle;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = c_st_wack;
          w_wr_en     = 1'b1;
        end
      end
      c_st_wack: begin
        if (!sync) w_state_nxt = c_st_idle;
        else if (dout) w_state_nxt = c_st_hold;
      end
      c_st_hold: begin
        // Only a second write may follow within one sync; din is ignored here.
        if (!sync) begin
          w_state_nxt = c_st_idle;
        end else if (!dout) begin
          w_state_nxt = c_st_wwait;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    rply    = 1'b1;
    sel_o   = 1'b0;
    w_ad_oe = 1'b0;
    if (r_state != c_st_idle) sel_o = 1'b1;
    if (r_state == c_st_rdrv || r_state == c_st_wack) rply = 1'b0;
    if (r_state == c_st_rdrv) w_ad_oe = 1'b1;
  end

  assign ad = w_ad_oe ? r_rdata : 16'hzzzz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= 4'd0;
      r_miss <= 1'b0;
      r_idx  <= '0;
      r_lane <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt <= c_wait;
      end else if ((r_state == c_st_rwait || r_state == c_st_wwait) && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // A missed cycle is remembered so the idle state ignores the bus until sync drops.
      if (!sync) begin
        r_miss <= 1'b0;
      end else if (w_latch && !w_hit) begin
        r_miss <= 1'b1;
      end
      if (w_latch) begin
        r_idx  <= w_diff[AW:1];
        r_lane <= w_diff[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (!wtbt || !r_lane) r_mem[r_idx][7:0]  <= ad[7:0];
      if (!wtbt || r_lane)  r_mem[r_idx][15:8] <= ad[15:8];
    end
    if (r_state == c_st_rwait) r_rdata <= r_mem[r_idx];
  end

endmodule
`default_nettype wire

// File: tb/tb_mpi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_mpi_ram_slave
// Brief    : Scoreboard bench for mpi_ram_slave across three parameter sets.
// Revision : 1.0  initial release
// ============================================================================
module tb_mpi_ram_slave;

  typedef struct {
    int          inst;
    bit          rd;
    logic [15:0] data;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sync_s [3];
  logic        din_s  [3];
  logic        dout_s [3];
  logic        wtbt_s [3];
  logic [15:0] drv    [3];
  logic        oe     [3];
  wire  [15:0] ad0, ad1, ad2;
  wire         rply0, rply1, rply2;
  wire         sel0, sel1, sel2;
  logic [15:0] ad_v   [3];
  logic        rply_v [3];
  logic        sel_v  [3];

  exp_t sb [$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   strobe [3];
  int   falls  [3];
  logic prev_rply [3];
  exp_t mon_e;
  int   mon_lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ad0 = oe[0] ? drv[0] : 16'hzzzz;
  assign ad1 = oe[1] ? drv[1] : 16'hzzzz;
  assign ad2 = oe[2] ? drv[2] : 16'hzzzz;
  // Released bus floats high so "not driven" reads back as FFFF.
  pullup (ad0);
  pullup (ad1);
  pullup (ad2);

  always_comb begin
    ad_v[0] = ad0;  ad_v[1] = ad1;  ad_v[2] = ad2;
    rply_v[0] = rply0;  rply_v[1] = rply1;  rply_v[2] = rply2;
    sel_v[0] = sel0;  sel_v[1] = sel1;  sel_v[2] = sel2;
  end

  mpi_ram_slave #(.BASE(16'h0000), .AW(13), .WAIT(1)) u_dut0 (
    .clk(clk), .reset(rst_n), .ad(ad0), .sync(sync_s[0]), .din(din_s[0]),
    .dout(dout_s[0]), .wtbt(wtbt_s[0]), .rply(rply0), .sel_o(sel0));
  mpi_ram_slave #(.BASE(16'h4000), .AW(13), .WAIT(0)) u_dut1 (
    .clk(clk), .reset(rst_n), .ad(ad1), .sync(sync_s[1]), .din(din_s[1]),
    .dout(dout_s[1]), .wtbt(wtbt_s[1]), .rply(rply1), .sel_o(sel1));
  mpi_ram_slave #(.BASE(16'h0000), .AW(13), .WAIT(15)) u_dut2 (
    .clk(clk), .reset(rst_n), .ad(ad2), .sync(sync_s[2]), .din(din_s[2]),
    .dout(dout_s[2]), .wtbt(wtbt_s[2]), .rply(rply2), .sel_o(sel2));

  function automatic int wait_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  // Monitor: every falling rply consumes one scoreboard entry.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (prev_rply[i] === 1'b1 && rply_v[i] === 1'b0) begin
        falls[i] = falls[i] + 1;
        vectors = vectors + 1;
        if (sb.size() == 0) begin
          miscompares = miscompares + 1;
          $display("FAIL reply_u%0d: got unexpected rply=0, want no reply", i);
        end else begin
          mon_e   = sb.pop_front();
          mon_lat = cyc - strobe[i] - 1;
          if (mon_e.inst != i || mon_lat != mon_e.lat || (mon_e.rd && ad_v[i] !== mon_e.data)) begin
            miscompares = miscompares + 1;
            $display("FAIL reply_u%0d: got inst=%0d lat=%0d ad=%h, want inst=%0d lat=%0d ad=%h",
                     i, i, mon_lat, ad_v[i], mon_e.inst, mon_e.lat, mon_e.data);
          end
        end
      end
      prev_rply[i] = rply_v[i];
    end
  end

  task automatic push_exp(input int i, input bit rd, input logic [15:0] d);
    exp_t e;
    e.inst = i;
    e.rd   = rd;
    e.data = d;
    e.lat  = wait_of(i) + 1;
    sb.push_back(e);
  endtask

  task automatic addr_phase(input int i, input logic [15:0] a, input logic wr);
    @(negedge clk);
    drv[i] = a;  oe[i] = 1'b1;  wtbt_s[i] = wr;  sync_s[i] = 1'b1;
  endtask

  task automatic end_cycle(input int i);
    @(negedge clk);
    sync_s[i] = 1'b0;  wtbt_s[i] = 1'b0;  oe[i] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_rply(input int i, input string nm);
    int n = 0;
    while (rply_v[i] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rply_v[i] !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got rply=%b after 40 cycles, want 0", nm, rply_v[i]);
    end
  endtask

  task automatic check_rel(input int i, input string nm);
    vectors++;
    if (rply_v[i] !== 1'b1 || ad_v[i] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL %s_release: got rply=%b ad=%h, want rply=1 ad=ffff", nm, rply_v[i], ad_v[i]);
    end
  endtask

  task automatic do_read(input int i, input logic [15:0] d, input string nm);
    @(negedge clk);
    oe[i] = 1'b0;  din_s[i] = 1'b0;  strobe[i] = cyc;
    push_exp(i, 1'b1, d);
    wait_rply(i, nm);
    @(negedge clk);
    din_s[i] = 1'b1;
    @(negedge clk);
    check_rel(i, nm);
  endtask

  task automatic do_write(input int i, input logic [15:0] d, input logic bt, input string nm);
    @(negedge clk);
    drv[i] = d;  oe[i] = 1'b1;  wtbt_s[i] = bt;  dout_s[i] = 1'b0;  strobe[i] = cyc;
    push_exp(i, 1'b0, d);
    wait_rply(i, nm);
    @(negedge clk);
    dout_s[i] = 1'b1;  oe[i] = 1'b0;
    @(negedge clk);
    check_rel(i, nm);
  endtask

  task automatic check_quiet(input int i, input int n, input logic es, input string nm);
    bit ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rply_v[i] !== 1'b1 || sel_v[i] !== es || ad_v[i] !== 16'hFFFF) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got rply=%b sel_o=%b ad=%h, want rply=1 sel_o=%b ad=ffff",
               nm, rply_v[i], sel_v[i], ad_v[i], es);
    end
  endtask

  task automatic miss_probe(input int i, input logic [15:0] a, input string nm);
    addr_phase(i, a, 1'b0);
    @(negedge clk);
    oe[i] = 1'b0;  din_s[i] = 1'b0;
    check_quiet(i, 8, 1'b0, nm);
    din_s[i] = 1'b1;
    end_cycle(i);
  endtask

  task automatic reset_check(input int i, input string nm);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (rply_v[i] !== 1'b1 || sel_v[i] !== 1'b0 || ad_v[i] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL %s: got rply=%b sel_o=%b ad=%h, want rply=1 sel_o=0 ad=ffff",
               nm, rply_v[i], sel_v[i], ad_v[i]);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sync_s[k] = 1'b0;  din_s[k] = 1'b1;  dout_s[k] = 1'b1;  wtbt_s[k] = 1'b0;  oe[k] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no summary by time limit, want finished run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    for (int k = 0; k < 3; k++) begin
      sync_s[k] = 1'b0;  din_s[k] = 1'b1;  dout_s[k] = 1'b1;  wtbt_s[k] = 1'b0;
      drv[k] = 16'h0000;  oe[k] = 1'b0;  strobe[k] = 0;  falls[k] = 0;  prev_rply[k] = 1'b1;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rply_v[k] !== 1'b1 || sel_v[k] !== 1'b0 || ad_v[k] !== 16'hFFFF) begin
        miscompares++;
        $display("FAIL reset_u%0d: got rply=%b sel_o=%b ad=%h, want rply=1 sel_o=0 ad=ffff",
                 k, rply_v[k], sel_v[k], ad_v[k]);
      end
    end

    // Word write then read back, WAIT=1
    addr_phase(0, 16'h0004, 1'b1);  do_write(0, 16'h1234, 1'b0, "t1_wr");  end_cycle(0);
    addr_phase(0, 16'h0004, 1'b0);  do_read(0, 16'h1234, "t1_rd");        end_cycle(0);

    // Byte writes into each lane
    addr_phase(0, 16'h0005, 1'b1);  do_write(0, 16'hAB00, 1'b1, "t2_wb_hi"); end_cycle(0);
    addr_phase(0, 16'h0004, 1'b0);  do_read(0, 16'hAB34, "t2_rd_hi");        end_cycle(0);
    addr_phase(0, 16'h0004, 1'b1);  do_write(0, 16'h00CD, 1'b1, "t2_wb_lo"); end_cycle(0);
    addr_phase(0, 16'h0004, 1'b0);  do_read(0, 16'hABCD, "t2_rd_lo");        end_cycle(0);

    // Read-modify-write inside one sync, with an ignored second din
    f0 = falls[0];
    addr_phase(0, 16'h0004, 1'b1);
    do_read(0, 16'hABCD, "t3_rd");
    do_write(0, 16'h5555, 1'b0, "t3_wr");
    @(negedge clk);
    din_s[0] = 1'b0;
    check_quiet(0, 6, 1'b1, "t3_hold_din");
    din_s[0] = 1'b1;
    end_cycle(0);
    vectors++;
    if (falls[0] - f0 != 2) begin
      miscompares++;
      $display("FAIL t3_pulses: got %0d rply pulses, want 2", falls[0] - f0);
    end
    addr_phase(0, 16'h0004, 1'b0);  do_read(0, 16'h5555, "t3_rd_new");  end_cycle(0);

    // Window edges at BASE=4000, WAIT=0
    miss_probe(1, 16'h3FFE, "t4_below");
    miss_probe(1, 16'h8000, "t4_above");
    addr_phase(1, 16'h7FFE, 1'b1);  do_write(1, 16'hBEEF, 1'b0, "t4_top_wr");  end_cycle(1);
    addr_phase(1, 16'h4000, 1'b1);  do_write(1, 16'h0F0F, 1'b0, "t4_bot_wr");  end_cycle(1);
    addr_phase(1, 16'h7FFE, 1'b0);  do_read(1, 16'hBEEF, "t4_top_rd");         end_cycle(1);
    addr_phase(1, 16'h4000, 1'b0);  do_read(1, 16'h0F0F, "t4_bot_rd");         end_cycle(1);

    // WAIT=15 latency
    addr_phase(2, 16'h0006, 1'b1);  do_write(2, 16'h2468, 1'b0, "t5_wr15");  end_cycle(2);
    addr_phase(2, 16'h0006, 1'b0);  do_read(2, 16'h2468, "t5_rd15");         end_cycle(2);

    // Reset during a pending write discards it
    addr_phase(2, 16'h0010, 1'b1);  do_write(2, 16'h1111, 1'b0, "t6_pre_wr");  end_cycle(2);
    addr_phase(2, 16'h0010, 1'b1);
    @(negedge clk);
    drv[2] = 16'hDEAD;  oe[2] = 1'b1;  wtbt_s[2] = 1'b0;  dout_s[2] = 1'b0;
    repeat (4) @(negedge clk);
    oe[2] = 1'b0;
    reset_check(2, "t6_rst_wwait");
    addr_phase(2, 16'h0010, 1'b0);  do_read(2, 16'h1111, "t6_keep");  end_cycle(2);

    // Reset while the slave drives ad
    addr_phase(2, 16'h0006, 1'b0);
    @(negedge clk);
    oe[2] = 1'b0;  din_s[2] = 1'b0;  strobe[2] = cyc;
    push_exp(2, 1'b1, 16'h2468);
    wait_rply(2, "t6_rdrv");
    #1;
    reset_check(2, "t6_rst_rdrv");

    // din with sync low gets no response
    @(negedge clk);
    din_s[0] = 1'b0;
    check_quiet(0, 10, 1'b0, "t6_no_sync");
    din_s[0] = 1'b1;

    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending replies, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
